// File: rtl/comm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comm_pkg
// Description : Shared widths, timing defaults and state encoding for the
//               parallel comm buffer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package comm_pkg;

    localparam int c_ADDR_W    = 9;
    localparam int c_DATA_W    = 4;
    localparam int c_DEPTH     = 256;
    localparam int c_SETUP_CYC = 2;
    localparam int c_PULSE_CYC = 2;
    localparam int c_HOLD_CYC  = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RESP  = 3'd4
    } seqState_t;

    // Largest of three phase lengths; sizes the shared phase counter.
    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage : comm_pkg
`default_nettype wire

// File: rtl/comm_paralel_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : comm_paralel_seq_if
// Description : Command/response handshake plus the external buffer bus of
//               the sequencer. The slave modport is the sequencer; the master
//               modport is its environment (command source and buffer).
// Revision    : 1.0 - initial release
// ============================================================================
interface comm_paralel_seq_if
    import comm_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
);
    logic              cmdValid;
    logic              cmdReady;
    logic              cmdWrite;
    logic [ADDR_W-1:0] cmdAddr;
    logic [DATA_W-1:0] cmdData;
    logic              rspValid;
    logic              rspErr;
    logic [DATA_W-1:0] rspData;
    logic [ADDR_W-1:0] busAddr;
    logic [DATA_W-1:0] busData;
    logic              storeStrb;
    logic              fetchStrb;
    logic [DATA_W-1:0] busIn;

    modport master (
        output cmdValid, cmdWrite, cmdAddr, cmdData, busIn,
        input  cmdReady, rspValid, rspErr, rspData,
        input  busAddr, busData, storeStrb, fetchStrb
    );

    modport slave (
        input  cmdValid, cmdWrite, cmdAddr, cmdData, busIn,
        output cmdReady, rspValid, rspErr, rspData,
        output busAddr, busData, storeStrb, fetchStrb
    );

endinterface : comm_paralel_seq_if
`default_nettype wire

// File: rtl/comm_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : comm_phase_timer
// Description : Shared down-counter for the SETUP/PULSE/HOLD phases. A start
//               with load N makes done high in the Nth cycle after the start
//               edge, i.e. in the last cycle of an N-cycle phase.
// Revision    : 1.0 - initial release
// ============================================================================
module comm_phase_timer #(
    parameter int CNT_W = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic [CNT_W-1:0] load,
    output logic                  done
);

    logic [CNT_W-1:0] r_count;
    logic             r_active;

    // Reload on start (start wins over an expiring phase), else count down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_count  <= load - CNT_W'(1);
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_count == '0) begin
                r_active <= 1'b0;
            end else begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign done = r_active && (r_count == '0);

endmodule : comm_phase_timer
`default_nettype wire

// File: rtl/comm_paralel_seq.sv
`default_nettype none
// ============================================================================
// Module      : comm_paralel_seq
// Description : Turns single-nibble read/write commands into one timed
//               store/fetch strobe on the parallel comm buffer bus and
//               returns a one-cycle response (with fetched nibble on reads).
// Revision    : 1.0 - initial release
// ============================================================================
module comm_paralel_seq
    import comm_pkg::*;
#(
    parameter int ADDR_W    = c_ADDR_W,
    parameter int DATA_W    = c_DATA_W,
    parameter int DEPTH     = c_DEPTH,
    parameter int SETUP_CYC = c_SETUP_CYC,
    parameter int PULSE_CYC = c_PULSE_CYC,
    parameter int HOLD_CYC  = c_HOLD_CYC
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    comm_paralel_seq_if.slave  link
);

    localparam int                c_cntW       = $clog2(maxOf3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   c_depthLimit = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_cntW-1:0] c_setupLoad  = c_cntW'(SETUP_CYC);
    localparam logic [c_cntW-1:0] c_pulseLoad  = c_cntW'(PULSE_CYC);
    localparam logic [c_cntW-1:0] c_holdLoad   = c_cntW'(HOLD_CYC);

    seqState_t         r_state;
    logic              r_write;
    logic              w_accept;
    logic              w_inRange;
    logic [DATA_W-1:0] w_writeNibble;
    logic              w_timerStart;
    logic [c_cntW-1:0] w_timerLoad;
    logic              w_timerDone;

    assign w_accept      = link.cmdValid && link.cmdReady;
    assign w_inRange     = ({1'b0, link.cmdAddr} < c_depthLimit);
    assign w_writeNibble = link.cmdWrite ? link.cmdData : '0;

    // Reload the shared timer on entry to each timed phase.
    always_comb begin
        w_timerStart = 1'b0;
        w_timerLoad  = c_setupLoad;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_inRange) begin
                    w_timerStart = 1'b1;
                    w_timerLoad  = c_setupLoad;
                end
            end
            ST_SETUP: begin
                if (w_timerDone) begin
                    w_timerStart = 1'b1;
                    w_timerLoad  = c_pulseLoad;
                end
            end
            ST_PULSE: begin
                if (w_timerDone) begin
                    w_timerStart = 1'b1;
                    w_timerLoad  = c_holdLoad;
                end
            end
            default: begin
                w_timerStart = 1'b0;
            end
        endcase
    end

    comm_phase_timer #(
        .CNT_W (c_cntW)
    ) u_phaseTimer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_timerStart),
        .load  (w_timerLoad),
        .done  (w_timerDone)
    );

    // Sequencer FSM; every bus and response output is set on the edge that
    // enters the state it belongs to, so all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_write        <= 1'b0;
            link.cmdReady  <= 1'b1;
            link.rspValid  <= 1'b0;
            link.rspErr    <= 1'b0;
            link.rspData   <= '0;
            link.busAddr   <= '0;
            link.busData   <= '0;
            link.storeStrb <= 1'b0;
            link.fetchStrb <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write       <= link.cmdWrite;
                        link.cmdReady <= 1'b0;
                        if (w_inRange) begin
                            link.busAddr <= link.cmdAddr;
                            link.busData <= w_writeNibble;
                            r_state      <= ST_SETUP;
                        end else begin
                            // Out-of-range: respond next cycle, bus untouched.
                            link.rspValid <= 1'b1;
                            link.rspErr   <= 1'b1;
                            link.rspData  <= '0;
                            r_state       <= ST_RESP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (w_timerDone) begin
                        link.storeStrb <= r_write;
                        link.fetchStrb <= !r_write;
                        r_state        <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (w_timerDone) begin
                        link.storeStrb <= 1'b0;
                        link.fetchStrb <= 1'b0;
                        r_state        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_timerDone) begin
                        // busIn is captured on the last hold cycle.
                        link.rspValid <= 1'b1;
                        link.rspErr   <= 1'b0;
                        link.rspData  <= r_write ? '0 : link.busIn;
                        link.busAddr  <= '0;
                        link.busData  <= '0;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    link.rspValid <= 1'b0;
                    link.rspErr   <= 1'b0;
                    link.rspData  <= '0;
                    link.cmdReady <= 1'b1;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    link.cmdReady <= 1'b1;
                end
            endcase
        end
    end

endmodule : comm_paralel_seq
`default_nettype wire

// File: tb/tb_comm_paralel_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_comm_paralel_seq
// Description : Directed bench for comm_paralel_seq: default timing instance
//               plus a 1/1/1 timing instance, each with a small buffer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comm_paralel_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   nAssert = 0;
    int   nFail   = 0;

    always #5 clk = ~clk;

    comm_paralel_seq_if #(.ADDR_W(9), .DATA_W(4)) ifA ();
    comm_paralel_seq_if #(.ADDR_W(9), .DATA_W(4)) ifF ();

    comm_paralel_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (ifA)
    );

    comm_paralel_seq #(
        .SETUP_CYC (1),
        .PULSE_CYC (1),
        .HOLD_CYC  (1)
    ) dutFast (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (ifF)
    );

    // Buffer models: store on storeStrb, present data on busIn after fetchStrb.
    logic [3:0] memA [256];
    logic [3:0] memF [256];

    always @(posedge clk) begin
        if (ifA.storeStrb) memA[ifA.busAddr[7:0]] <= ifA.busData;
        if (ifF.storeStrb) memF[ifF.busAddr[7:0]] <= ifF.busData;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifA.busIn <= 4'h0;
            ifF.busIn <= 4'h0;
        end else begin
            if (ifA.fetchStrb) ifA.busIn <= memA[ifA.busAddr[7:0]];
            if (ifF.fetchStrb) ifF.busIn <= memF[ifF.busAddr[7:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issueA(input logic w, input logic [8:0] a, input logic [3:0] d);
        ifA.cmdValid = 1'b1;
        ifA.cmdWrite = w;
        ifA.cmdAddr  = a;
        ifA.cmdData  = d;
        tick();
        ifA.cmdValid = 1'b0;
    endtask

    task automatic issueF(input logic w, input logic [8:0] a, input logic [3:0] d);
        ifF.cmdValid = 1'b1;
        ifF.cmdWrite = w;
        ifF.cmdAddr  = a;
        ifF.cmdData  = d;
        tick();
        ifF.cmdValid = 1'b0;
    endtask

    initial begin
        ifA.cmdValid = 1'b0; ifA.cmdWrite = 1'b0; ifA.cmdAddr = '0; ifA.cmdData = '0;
        ifF.cmdValid = 1'b0; ifF.cmdWrite = 1'b0; ifF.cmdAddr = '0; ifF.cmdData = '0;

        // ---- reset state ----
        repeat (3) tick();
        chk("rst cmdReady",  16'(ifA.cmdReady),  16'h1);
        chk("rst rspValid",  16'(ifA.rspValid),  16'h0);
        chk("rst storeStrb", 16'(ifA.storeStrb), 16'h0);
        chk("rst fetchStrb", 16'(ifA.fetchStrb), 16'h0);
        chk("rst busAddr",   16'(ifA.busAddr),   16'h0);
        chk("rst rspData",   16'(ifA.rspData),   16'h0);
        chk("rst fast cmdReady", 16'(ifF.cmdReady), 16'h1);
        rst_n = 1'b1;
        tick();
        chk("post-rst cmdReady", 16'(ifA.cmdReady), 16'h1);

        // ---- write 0x005 <- 0xA ----
        issueA(1'b1, 9'h005, 4'hA);
        ifA.cmdAddr = 9'h1AB;   // changes after accept must not matter
        ifA.cmdData = 4'h3;
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("wr c%0d storeStrb", c), 16'(ifA.storeStrb), 16'((c == 3 || c == 4) ? 1 : 0));
            chk($sformatf("wr c%0d fetchStrb", c), 16'(ifA.fetchStrb), 16'h0);
            chk($sformatf("wr c%0d busAddr", c),   16'(ifA.busAddr),   (c <= 5) ? 16'h005 : 16'h0);
            chk($sformatf("wr c%0d busData", c),   16'(ifA.busData),   (c <= 5) ? 16'hA : 16'h0);
            chk($sformatf("wr c%0d rspValid", c),  16'(ifA.rspValid),  16'((c == 6) ? 1 : 0));
            chk($sformatf("wr c%0d rspErr", c),    16'(ifA.rspErr),    16'h0);
            chk($sformatf("wr c%0d cmdReady", c),  16'(ifA.cmdReady),  16'((c == 7) ? 1 : 0));
            tick();
        end

        // ---- read 0x005, expect 0xA ----
        issueA(1'b0, 9'h005, 4'hF);
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("rd c%0d fetchStrb", c), 16'(ifA.fetchStrb), 16'((c == 3 || c == 4) ? 1 : 0));
            chk($sformatf("rd c%0d storeStrb", c), 16'(ifA.storeStrb), 16'h0);
            chk($sformatf("rd c%0d busAddr", c),   16'(ifA.busAddr),   (c <= 5) ? 16'h005 : 16'h0);
            chk($sformatf("rd c%0d busData", c),   16'(ifA.busData),   16'h0);
            chk($sformatf("rd c%0d rspValid", c),  16'(ifA.rspValid),  16'((c == 6) ? 1 : 0));
            chk($sformatf("rd c%0d rspData", c),   16'(ifA.rspData),   (c == 6) ? 16'hA : 16'h0);
            tick();
        end

        // ---- out-of-range write 0x100 ----
        issueA(1'b1, 9'h100, 4'h7);
        chk("err c1 rspValid",  16'(ifA.rspValid),  16'h1);
        chk("err c1 rspErr",    16'(ifA.rspErr),    16'h1);
        chk("err c1 rspData",   16'(ifA.rspData),   16'h0);
        chk("err c1 storeStrb", 16'(ifA.storeStrb), 16'h0);
        chk("err c1 fetchStrb", 16'(ifA.fetchStrb), 16'h0);
        chk("err c1 busAddr",   16'(ifA.busAddr),   16'h0);
        chk("err c1 cmdReady",  16'(ifA.cmdReady),  16'h0);
        tick();
        chk("err c2 cmdReady",  16'(ifA.cmdReady),  16'h1);
        chk("err c2 rspValid",  16'(ifA.rspValid),  16'h0);
        chk("err c2 storeStrb", 16'(ifA.storeStrb), 16'h0);
        tick();

        // ---- back-to-back: 0x0FF<-0x3 then 0x000<-0x5, cmdValid held ----
        ifA.cmdValid = 1'b1;
        ifA.cmdWrite = 1'b1;
        ifA.cmdAddr  = 9'h0FF;
        ifA.cmdData  = 4'h3;
        tick();
        for (int c = 1; c <= 14; c++) begin
            chk($sformatf("b2b c%0d storeStrb", c), 16'(ifA.storeStrb),
                16'((c == 3 || c == 4 || c == 10 || c == 11) ? 1 : 0));
            chk($sformatf("b2b c%0d busAddr", c), 16'(ifA.busAddr), (c <= 5) ? 16'h0FF : 16'h0);
            chk($sformatf("b2b c%0d busData", c), 16'(ifA.busData),
                (c <= 5) ? 16'h3 : ((c >= 8 && c <= 12) ? 16'h5 : 16'h0));
            chk($sformatf("b2b c%0d rspValid", c), 16'(ifA.rspValid), 16'((c == 6 || c == 13) ? 1 : 0));
            chk($sformatf("b2b c%0d rspErr", c),   16'(ifA.rspErr),   16'h0);
            chk($sformatf("b2b c%0d cmdReady", c), 16'(ifA.cmdReady), 16'((c == 7 || c == 14) ? 1 : 0));
            if (c == 1) begin
                ifA.cmdAddr = 9'h000;
                ifA.cmdData = 4'h5;
            end
            if (c == 8) ifA.cmdValid = 1'b0;
            tick();
        end

        // ---- reset asserted during PULSE ----
        issueA(1'b1, 9'h010, 4'h7);
        tick();
        tick();
        chk("rstmid c3 storeStrb", 16'(ifA.storeStrb), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid async storeStrb", 16'(ifA.storeStrb), 16'h0);
        chk("rstmid async cmdReady",  16'(ifA.cmdReady),  16'h1);
        chk("rstmid async busAddr",   16'(ifA.busAddr),   16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("rstmid c%0d rspValid", c), 16'(ifA.rspValid),  16'h0);
            chk($sformatf("rstmid c%0d storeStrb", c), 16'(ifA.storeStrb), 16'h0);
            tick();
        end
        chk("rstmid cmdReady", 16'(ifA.cmdReady), 16'h1);

        issueA(1'b0, 9'h005, 4'h0);
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("rd2 c%0d fetchStrb", c), 16'(ifA.fetchStrb), 16'((c == 3 || c == 4) ? 1 : 0));
            chk($sformatf("rd2 c%0d rspValid", c),  16'(ifA.rspValid),  16'((c == 6) ? 1 : 0));
            chk($sformatf("rd2 c%0d rspData", c),   16'(ifA.rspData),   (c == 6) ? 16'hA : 16'h0);
            tick();
        end

        // ---- 1/1/1 timing instance: write 0x005<-0xC, then read it ----
        issueF(1'b1, 9'h005, 4'hC);
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("fwr c%0d storeStrb", c), 16'(ifF.storeStrb), 16'((c == 2) ? 1 : 0));
            chk($sformatf("fwr c%0d rspValid", c),  16'(ifF.rspValid),  16'((c == 4) ? 1 : 0));
            chk($sformatf("fwr c%0d cmdReady", c),  16'(ifF.cmdReady),  16'((c == 5) ? 1 : 0));
            tick();
        end
        issueF(1'b0, 9'h005, 4'h0);
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("frd c%0d fetchStrb", c), 16'(ifF.fetchStrb), 16'((c == 2) ? 1 : 0));
            chk($sformatf("frd c%0d busAddr", c),   16'(ifF.busAddr),   (c <= 3) ? 16'h005 : 16'h0);
            chk($sformatf("frd c%0d rspValid", c),  16'(ifF.rspValid),  16'((c == 4) ? 1 : 0));
            chk($sformatf("frd c%0d rspData", c),   16'(ifF.rspData),   (c == 4) ? 16'hC : 16'h0);
            chk($sformatf("frd c%0d cmdReady", c),  16'(ifF.cmdReady),  16'((c == 5) ? 1 : 0));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule : tb_comm_paralel_seq
`default_nettype wire
